// File: rtl/lcd_bus_driver.sv
// HD44780-compatible 8-bit write-only bus driver: power-on init, then one
// command (dr/direc) or data byte (wr/dbi) per request with full bus timing.
module lcd_bus_driver #(
  parameter int T_PWR  = 300000,
  parameter int T_AS   = 2,
  parameter int T_EPW  = 10,
  parameter int T_AH   = 2,
  parameter int T_EXEC = 800,
  parameter int T_LONG = 32000
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       wr,
  input  logic       dr,
  input  logic [7:0] dbi,
  input  logic [7:0] direc,
  output logic       busy,
  output logic       init_done,
  output logic       overrun,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  localparam int P_PWR  = (T_PWR  < 1) ? 1 : T_PWR;
  localparam int P_AS   = (T_AS   < 1) ? 1 : T_AS;
  localparam int P_EPW  = (T_EPW  < 1) ? 1 : T_EPW;
  localparam int P_AH   = (T_AH   < 1) ? 1 : T_AH;
  localparam int P_EXEC = (T_EXEC < 1) ? 1 : T_EXEC;
  localparam int P_LONG = (T_LONG < 1) ? 1 : T_LONG;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int P_MAX = max2(max2(P_PWR, P_LONG),
                              max2(max2(P_AS + 1, P_EPW), max2(P_AH, P_EXEC)));
  localparam int W     = $clog2(P_MAX + 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_LOAD     = 3'd1,
    S_SETUP    = 3'd2,
    S_EPULSE   = 3'd3,
    S_HOLD     = 3'd4,
    S_EXEC     = 3'd5,
    S_IDLE     = 3'd6
  } state_t;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      2'd3:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  state_t         r_state;
  logic [W-1:0]   r_cnt;
  logic [1:0]     r_idx;
  logic           r_busy;
  logic           r_init_done;
  logic           r_overrun;
  logic           r_rs;
  logic           r_rw;
  logic           r_e;
  logic [7:0]     r_db;

  logic [W-1:0]   w_lim;
  logic           w_long;
  logic           w_done;

  // Per-state terminal count; a normal-phase SETUP also absorbs the acceptance cycle.
  always_comb begin
    w_long = 1'b0;
    if ((r_rs == 1'b0) && (r_db[7:2] == 6'd0) && (r_db != 8'h00)) begin
      w_long = 1'b1;
    end else begin
      w_long = 1'b0;
    end
    w_lim = W'(0);
    case (r_state)
      S_PWR_WAIT: w_lim = W'(P_PWR - 1);
      S_SETUP: begin
        if (r_init_done) begin
          w_lim = W'(P_AS);
        end else begin
          w_lim = W'(P_AS - 1);
        end
      end
      S_EPULSE:   w_lim = W'(P_EPW - 1);
      S_HOLD:     w_lim = W'(P_AH - 1);
      S_EXEC: begin
        if (w_long) begin
          w_lim = W'(P_LONG - 1);
        end else begin
          w_lim = W'(P_EXEC - 1);
        end
      end
      default:    w_lim = W'(0);
    endcase
    w_done = (r_cnt == w_lim);
  end

  // Sequencer, bus registers and status flags.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state     <= S_PWR_WAIT;
      r_cnt       <= W'(0);
      r_idx       <= 2'd0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_overrun   <= 1'b0;
      r_rs        <= 1'b0;
      r_rw        <= 1'b0;
      r_e         <= 1'b0;
      r_db        <= 8'h00;
    end else begin
      r_cnt <= r_cnt + W'(1);
      r_rw  <= 1'b0;
      if ((dr || wr) && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_PWR_WAIT: begin
          if (w_done) begin
            r_state <= S_LOAD;
            r_cnt   <= W'(0);
            r_idx   <= 2'd0;
          end
        end
        S_LOAD: begin
          r_rs    <= 1'b0;
          r_db    <= init_rom(r_idx);
          r_state <= S_SETUP;
          r_cnt   <= W'(0);
        end
        S_SETUP: begin
          if (w_done) begin
            r_state <= S_EPULSE;
            r_e     <= 1'b1;
            r_cnt   <= W'(0);
          end
        end
        S_EPULSE: begin
          if (w_done) begin
            r_state <= S_HOLD;
            r_e     <= 1'b0;
            r_cnt   <= W'(0);
          end
        end
        S_HOLD: begin
          if (w_done) begin
            r_state <= S_EXEC;
            r_cnt   <= W'(0);
          end
        end
        S_EXEC: begin
          if (w_done) begin
            r_cnt <= W'(0);
            if (!r_init_done && (r_idx != 2'd3)) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_LOAD;
            end else begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          r_cnt <= W'(0);
          // Command wins a same-cycle collision; the data byte is lost.
          if (dr) begin
            r_rs    <= 1'b0;
            r_db    <= direc;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
            if (wr) begin
              r_overrun <= 1'b1;
            end
          end else if (wr) begin
            r_rs    <= 1'b1;
            r_db    <= dbi;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        default: begin
          r_state <= S_PWR_WAIT;
          r_cnt   <= W'(0);
          r_busy  <= 1'b1;
          r_e     <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign overrun   = r_overrun;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = r_rw;
  assign lcd_e     = r_e;
  assign lcd_db    = r_db;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver with short timing: table of requests plus init,
// collision, overrun and mid-pulse reset sequences; E pulses are scoreboarded.
module tb_lcd_bus_driver;

  logic       clk2 = 1'b0;
  logic       rst  = 1'b1;
  logic       wr   = 1'b0;
  logic       dr   = 1'b0;
  logic [7:0] dbi  = 8'h00;
  logic [7:0] direc = 8'h00;
  logic       busy, init_done, overrun, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_bus_driver #(
    .T_PWR(20), .T_AS(1), .T_EPW(2), .T_AH(1), .T_EXEC(4), .T_LONG(10)
  ) dut (
    .clk2(clk2), .rst(rst), .wr(wr), .dr(dr), .dbi(dbi), .direc(direc),
    .busy(busy), .init_done(init_done), .overrun(overrun),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  always #5 clk2 = ~clk2;

  typedef struct {
    logic       dr;
    logic       wr;
    logic [7:0] direc;
    logic [7:0] dbi;
    int         inj;
    logic       exp_rs;
    logic [7:0] exp_db;
    int         exp_busy;
    logic       exp_ovr;
  } vec_t;

  vec_t       vecs[9];
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  // E-pulse scoreboard: each rising edge pops the expected {rs, db}; width checked on fall.
  logic       mon_prev_e = 1'b0;
  int         mon_w = 0;
  logic [8:0] mon_item;
  always @(negedge clk2) begin
    if (lcd_e === 1'b1 && mon_prev_e == 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_e_pulse: got rs=%0b db=0x%0h with no pulse expected", lcd_rs, lcd_db);
      end else begin
        mon_item = exp_q.pop_front();
        chk("e_rise_bus", {23'd0, lcd_rs, lcd_db}, {23'd0, mon_item});
      end
      mon_w = 1;
    end else if (lcd_e === 1'b1) begin
      mon_w++;
    end else if (mon_prev_e && !rst) begin
      chk("e_width", mon_w, 2);
    end
    mon_prev_e = lcd_e;
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  // Called on the first cycle after rst is released.
  task automatic check_init();
    int   rises[$];
    int   exp_r[4];
    int   done_at;
    int   early_idle;
    logic pe;
    exp_r = '{22, 31, 40, 55};
    done_at = -1;
    early_idle = 0;
    pe = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) step();
      if (lcd_e && !pe) rises.push_back(c);
      pe = lcd_e;
      if (init_done) begin
        done_at = c;
        break;
      end
      if (!busy) early_idle++;
    end
    chk("init_done_cycle", done_at, 62);
    chk("busy_at_init_done", {31'd0, busy}, 32'd0);
    chk("busy_low_before_init", early_idle, 0);
    chk("init_pulse_count", rises.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rises.size()) chk("init_pulse_start", rises[i], exp_r[i]);
    end
  endtask

  // Called with the DUT in IDLE at a sample point.
  task automatic run_vec(input vec_t v);
    int   busy_n;
    int   e_at;
    logic pe;
    busy_n = 0;
    e_at = -1;
    chk("idle_before_req", {31'd0, busy}, 32'd0);
    dr = v.dr;
    wr = v.wr;
    direc = v.direc;
    dbi = v.dbi;
    exp_q.push_back({v.exp_rs, v.exp_db});
    step();
    dr = 1'b0;
    wr = 1'b0;
    chk("accept_bus", {23'd0, lcd_rs, lcd_db}, {23'd0, v.exp_rs, v.exp_db});
    chk("accept_busy", {31'd0, busy}, 32'd1);
    pe = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (c > 1) step();
      wr = (c == v.inj);
      if (c == v.inj) dbi = 8'hAA;
      if (lcd_e && !pe && e_at < 0) e_at = c;
      pe = lcd_e;
      if (busy) busy_n++;
      else break;
    end
    wr = 1'b0;
    chk("busy_cycles", busy_n, v.exp_busy);
    chk("e_rise_cycle", e_at, 3);
    chk("bus_hold", {23'd0, lcd_rs, lcd_db}, {23'd0, v.exp_rs, v.exp_db});
    chk("overrun", {31'd0, overrun}, {31'd0, v.exp_ovr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h45, 0, 1'b1, 8'h45,  9, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h86, 8'h00, 0, 1'b0, 8'h86,  9, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h01, 8'h00, 0, 1'b0, 8'h01, 15, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'hC5, 8'h3A, 0, 1'b0, 8'hC5,  9, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h41, 0, 1'b1, 8'h41,  9, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h52, 0, 1'b1, 8'h52,  9, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h80, 8'h00, 3, 1'b0, 8'h80,  9, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h02, 8'h00, 0, 1'b0, 8'h02, 15, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h21, 0, 1'b1, 8'h21,  9, 1'b1};

    for (int i = 0; i < 3; i++) step();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_bus", {22'd0, lcd_rs, lcd_rw, lcd_e, lcd_db}, 32'd0);

    push_init();
    rst = 1'b0;
    check_init();
    chk("overrun_after_init", {31'd0, overrun}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset while E is high, then the whole init must repeat.
    wr = 1'b1;
    dbi = 8'h55;
    exp_q.push_back({1'b1, 8'h55});
    step();
    wr = 1'b0;
    wait_n = 0;
    while (!lcd_e && wait_n < 10) begin
      step();
      wait_n++;
    end
    chk("e_seen_before_rst", {31'd0, lcd_e}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    chk("rst_mid_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_mid_overrun", {31'd0, overrun}, 32'd0);
    step();
    push_init();
    rst = 1'b0;
    check_init();

    for (int i = 5; i < 9; i++) run_vec(vecs[i]);

    for (int i = 0; i < 3; i++) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Physical-side consumer of the LCD menu writers' request strobes.
- Accepts single-byte requests: a command on dr with address/instruction on direc, or character data on wr with code on dbi.
- Drives an HD44780-compatible 8-bit parallel bus (RS, RW, E, DB) with setup, enable-pulse, hold and execution timing.
- Performs the power-on initialisation itself, and exposes busy/init_done so writers can pace their sequences.

Parameters:
T_PWR, 300000, clk2 cycles of power-on wait before the first init command (15 ms @ 20 MHz)
T_AS, 2, cycles RS/DB are stable before E rises
T_EPW, 10, cycles E is held high
T_AH, 2, cycles RS/DB are held after E falls
T_EXEC, 800, execution wait after normal commands and data (40 us)
T_LONG, 32000, execution wait after clear/home commands (1.6 ms)

Ports:
clk2  in  1  system clock for all logic
rst  in  1  synchronous reset, active-high
wr  in  1  data-write request, sampled each clk2 edge
dr  in  1  command request, sampled each clk2 edge
dbi  in  8  character code used with wr
direc  in  8  instruction/DDRAM address used with dr
busy  out  1  1 = request will not be accepted this cycle
init_done  out  1  1 once the init sequence completes; sticky until rst
overrun  out  1  sticky: a request was dropped; cleared only by rst
lcd_rs  out  1  register select (0 command, 1 data)
lcd_rw  out  1  constant 0 (write-only bus)
lcd_e  out  1  enable strobe
lcd_db  out  8  bus data

Behaviour:
Interface decisions:
- Reset is rst, synchronous, active-high; clock is clk2. All outputs are registered.
- Reset values: state=PWR_WAIT, busy=1, init_done=0, overrun=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=0, all counters 0, init index 0.

States: PWR_WAIT, LOAD, SETUP, EPULSE, HOLD, EXEC, IDLE.
- PWR_WAIT: count T_PWR cycles, then go to LOAD with init index 0.
- LOAD:
  - Init phase: drive lcd_rs=0 and lcd_db from the init ROM by index, in order 0x38, 0x0C, 0x01, 0x06.
  - Normal phase: the byte latched at acceptance is already on the bus.
  - Then go to SETUP.
- SETUP: hold for T_AS cycles, lcd_e=0.
- EPULSE: lcd_e=1 for exactly T_EPW cycles.
- HOLD: lcd_e=0 for T_AH cycles; RS/DB unchanged.
- EXEC: wait for the execution time.
  - Use T_LONG when the byte is a command with value[7:2]==0 and value!=0 (clear 0x01, home 0x02/0x03); otherwise T_EXEC.
  - Init phase: increment index and return to LOAD, or after index 3 set init_done=1 and go to IDLE.
  - Normal phase: go to IDLE.
- IDLE: busy=0; busy is 1 in every other state.

Acceptance:
- In IDLE, dr=1 or wr=1 at a clk2 edge is accepted.
- Next cycle: lcd_rs=0/lcd_db=direc for dr, or lcd_rs=1/lcd_db=dbi for wr; busy=1; state goes straight to SETUP.
- Total busy cycles per request = 1 + T_AS + T_EPW + T_AH + exec wait, then busy drops.

Boundary conditions:
- dr and wr both high in IDLE: the command (dr) wins and overrun is set.
- dr or wr high while busy=1, including during PWR_WAIT/init: the request is dropped and overrun is set. This is never queued.
- Level-held requests: a request still high on the first IDLE cycle is accepted again. Writers must pulse for 1 cycle per byte.
- rst mid-transaction: on the next edge lcd_e=0 and the state is PWR_WAIT; the full init is repeated and init_done clears.
- Counters must be wide enough for T_PWR with no wrap; a zero value of any T_* is treated as 1.

Test Plan:
(Overrides: T_PWR=20, T_AS=1, T_EPW=2, T_AH=1, T_EXEC=4, T_LONG=10.)
1. Release rst, idle inputs:
   - lcd_e stays 0 for 20 cycles.
   - Then four E pulses, each 2 cycles wide, with lcd_db 0x38, 0x0C, 0x01, 0x06 and lcd_rs=0.
   - Gap after 0x01 uses the 10-cycle wait.
   - Then init_done=1 and busy=0.
2. After init, 1-cycle wr with dbi=0x45:
   - Next cycle lcd_rs=1, lcd_db=0x45, busy=1.
   - E high on cycles +3..+4.
   - busy low again after exactly 1+1+2+1+4=9 cycles.
3. 1-cycle dr with direc=0x86 -> lcd_rs=0, lcd_db=0x86, 9-cycle busy. Then dr with direc=0x01 -> 15-cycle busy (T_LONG path).
4. wr pulse on the 3rd busy cycle of a transaction:
   - Bus unchanged and no extra E pulse.
   - overrun=1, still 1 after later good requests.
5. dr=1, wr=1 same cycle in IDLE with direc=0xC5, dbi=0x3A -> lcd_rs=0, lcd_db=0xC5, overrun=1, only one E pulse.
6. Assert rst while lcd_e=1:
   - Next edge lcd_e=0, busy=1, init_done=0.
   - After release, the full init sequence from scenario 1 repeats.
